register_bank: RTL and testbench

- MIPS register file: the receiving end of the write-back interface. It consumes write data, write register and RegWrite from the write-back stage.
- Serves two registered read ports to the decode stage, which are latched into the ID/EX boundary.
- Provides a combinational debug read port for the debug unit.
- Counts retired register writes for debug visibility.

---
 rtl/register_bank.sv | 94 +++++++++
 tb/tb_register_bank.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// register_bank: MIPS general-purpose register file.
// Write-back drives the write side. Decode reads through two registered
// ports with write-first forwarding. A combinational port serves the debug
// unit, and a saturating counter records retired register writes.
//
// Handshake: i_valid is a one-way enable from decode, with no ready signal.
// On a rising edge with i_valid=1, both read ports capture fresh data.
// With i_valid=0, both read ports hold their previous value. Writes from
// write-back never depend on i_valid.
module register_bank #(
  parameter int LEN                  = 32,
  parameter int NB_ADDRESS_REGISTROS = 5,
  parameter int N_REGISTROS          = 32,
  parameter int NB_COUNT             = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_valid,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_read_reg_1,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_read_reg_2,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg,
  input  logic [LEN-1:0]                  i_write_data,
  input  logic                            i_RegWrite,
  input  logic [NB_ADDRESS_REGISTROS-1:0] i_debug_addr,
  output logic [LEN-1:0]                  o_read_data_1,
  output logic [LEN-1:0]                  o_read_data_2,
  output logic [LEN-1:0]                  o_debug_data,
  output logic [NB_COUNT-1:0]             o_write_count
);

  logic [LEN-1:0] regs [N_REGISTROS];
  logic           write_hit;
  logic [LEN-1:0] bypass_1;
  logic [LEN-1:0] bypass_2;

  // A write to register 0 is not an effective write: it is dropped and not counted.
  assign write_hit = i_RegWrite && (i_write_reg != '0);

  // Read-port operand selection: r0 reads zero, then same-cycle write wins, then the array.
  always_comb begin
    bypass_1 = regs[i_read_reg_1];
    bypass_2 = regs[i_read_reg_2];
    if (i_read_reg_1 == '0) begin
      bypass_1 = '0;
    end else if (write_hit && (i_write_reg == i_read_reg_1)) begin
      bypass_1 = i_write_data;
    end
    if (i_read_reg_2 == '0) begin
      bypass_2 = '0;
    end else if (write_hit && (i_write_reg == i_read_reg_2)) begin
      bypass_2 = i_write_data;
    end
  end

  // Register array. Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_REGISTROS; i++) begin
        regs[i] <= '0;
      end
    end else if (write_hit) begin
      regs[i_write_reg] <= i_write_data;
    end
  end

  // Registered read ports. They hold while decode is stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_read_data_1 <= '0;
      o_read_data_2 <= '0;
    end else if (i_valid) begin
      o_read_data_1 <= bypass_1;
      o_read_data_2 <= bypass_2;
    end
  end

  // Retired-write counter. It sticks at all-ones instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_write_count <= '0;
    end else if (write_hit && (o_write_count != '1)) begin
      o_write_count <= o_write_count + 1'b1;
    end
  end

  // Debug view of the committed array, with no forwarding. Address 0 reads zero.
  always_comb begin
    o_debug_data = regs[i_debug_addr];
    if (i_debug_addr == '0) begin
      o_debug_data = '0;
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: randomized plus directed checks of register_bank
// against a behavioural register-file model.
module tb_register_bank;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [4:0]  read_reg_1;
  logic [4:0]  read_reg_2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [4:0]  debug_addr;
  logic [31:0] read_data_1;
  logic [31:0] read_data_2;
  logic [31:0] debug_data;
  logic [15:0] write_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain array, expected outputs and an integer counter.
  logic [31:0] m_regs [32];
  logic [31:0] m_rd1;
  logic [31:0] m_rd2;
  int unsigned m_cnt;

  register_bank dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_valid       (valid),
    .i_read_reg_1  (read_reg_1),
    .i_read_reg_2  (read_reg_2),
    .i_write_reg   (write_reg),
    .i_write_data  (write_data),
    .i_RegWrite    (reg_write),
    .i_debug_addr  (debug_addr),
    .o_read_data_1 (read_data_1),
    .o_read_data_2 (read_data_2),
    .o_debug_data  (debug_data),
    .o_write_count (write_count)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_rd1 = '0;
    m_rd2 = '0;
    m_cnt = 0;
  endtask

  // Value seen by a read port: r0 is zero, and a same-cycle effective write is seen first.
  function automatic logic [31:0] model_read(input logic [4:0] a, input logic eff,
                                             input logic [4:0] wa, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (eff && wa == a) return wd;
    return m_regs[a];
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, "_rd1"}, read_data_1, m_rd1);
    check_eq({tag, "_rd2"}, read_data_2, m_rd2);
    check_eq({tag, "_cnt"}, {16'h0, write_count}, m_cnt);
    check_eq({tag, "_dbg"}, debug_data, m_regs[debug_addr]);
  endtask

  // Driver: present one cycle of inputs, advance the model, then compare after the edge.
  task automatic do_cycle(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                          input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [4:0] da, input bit chk, input string tag);
    logic eff;
    @(negedge clk);
    valid = v; read_reg_1 = a1; read_reg_2 = a2;
    reg_write = we; write_reg = wa; write_data = wd; debug_addr = da;
    eff = we && (wa != 0);
    if (v) begin
      m_rd1 = model_read(a1, eff, wa, wd);
      m_rd2 = model_read(a2, eff, wa, wd);
    end
    if (eff) begin
      m_regs[wa] = wd;
      if (m_cnt < 65535) m_cnt++;
    end
    @(posedge clk);
    #1;
    if (chk) check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; read_reg_1 = '0; read_reg_2 = '0;
    write_reg = '0; write_data = '0; reg_write = 1'b0; debug_addr = '0;
    model_reset();
    #2;
    check_all("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset after reg 5 holds 0xDEADBEEF.
    do_cycle(1, 0, 0, 1, 5, 32'hDEADBEEF, 5, 1, "w5");
    do_cycle(1, 5, 5, 0, 0, 0, 5, 1, "r5");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Write, then read one cycle later.
    do_cycle(1, 0, 0, 1, 7, 32'h12345678, 7, 1, "w7");
    do_cycle(1, 7, 0, 0, 0, 0, 7, 1, "r7");
    check_eq("cnt_one", {16'h0, write_count}, 32'd1);

    // Same-cycle bypass to both ports.
    do_cycle(1, 0, 0, 1, 3, 32'h1, 3, 1, "w3");
    do_cycle(1, 3, 3, 1, 3, 32'hAAAA5555, 3, 1, "byp3");
    check_eq("byp_rd1", read_data_1, 32'hAAAA5555);

    // Register 0 ignores writes.
    do_cycle(1, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 1, "r0");

    // Stall: outputs hold while the write retires anyway.
    do_cycle(1, 0, 0, 1, 10, 32'h11, 0, 1, "w10");
    do_cycle(1, 0, 0, 1, 11, 32'h22, 0, 1, "w11");
    do_cycle(1, 10, 11, 0, 0, 0, 0, 1, "r1011");
    do_cycle(0, 1, 11, 1, 1, 32'h99, 1, 1, "stall");
    check_eq("stall_hold", read_data_1, 32'h11);
    do_cycle(1, 1, 11, 0, 0, 0, 1, 1, "resume");
    check_eq("resume_rd1", read_data_1, 32'h99);

    // Reset during a write cycle drops that write.
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd9; write_data = 32'hCAFEF00D; valid = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_cycle(1, 9, 0, 0, 0, 0, 9, 1, "rst_drop");

    // Randomized traffic, biased toward a few registers so forwarding is exercised.
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] a1, a2, wa, da;
      a1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      wa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      da = 5'($urandom_range(0, 31));
      do_cycle($urandom_range(0, 3) != 0, a1, a2, 1'($urandom_range(0, 1)), wa, $urandom,
               da, 1, "rand");
    end

    // Saturate the counter with effective writes, then confirm it sticks.
    for (int n = 0; n < 65537; n++) begin
      do_cycle(0, 0, 0, 1, 5'($urandom_range(1, 31)), $urandom, 0, 0, "sat");
    end
    #1;
    check_eq("sat_cnt", {16'h0, write_count}, 32'h0000FFFF);
    do_cycle(1, 4, 6, 1, 12, 32'h5A5A5A5A, 12, 1, "sat_more");
    do_cycle(1, 0, 12, 1, 0, 32'hFFFFFFFF, 0, 1, "sat_r0");
    check_eq("sat_final", {16'h0, write_count}, 32'h0000FFFF);

    for (int n = 0; n < 50; n++) begin
      do_cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
               5'($urandom_range(0, 31)), 1, "rand_sat");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
